// File: rtl/perf_ctl_pkg.sv
// Shared definitions for the performance-counter control path: command codes,
// sequencer states and the counter slave address map.
package perf_ctl_pkg;

    typedef enum logic [1:0] {
        CMD_GO        = 2'b00,
        CMD_STOP      = 2'b01,
        CMD_CLEAR_ALL = 2'b10,
        CMD_SNAPSHOT  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD_HI0 = 3'd2,
        RD_LO  = 3'd3,
        RD_HI1 = 3'd4,
        RD_EV  = 3'd5,
        CHK    = 3'd6,
        RSP    = 3'd7
    } state_e;

    localparam logic [2:0] OFF_STOP   = 3'd0;
    localparam logic [2:0] OFF_GO     = 3'd1;
    localparam logic [2:0] OFF_EV     = 3'd2;
    localparam logic [2:0] SEC_STRIDE = 3'd4;

    // Reads share the write offsets: the time LO word sits at STOP, HI at GO.
    localparam logic [2:0] OFF_LO = OFF_STOP;
    localparam logic [2:0] OFF_HI = OFF_GO;

    function automatic logic [2:0] sec_base(input logic sec);
        return sec ? SEC_STRIDE : 3'd0;
    endfunction

endpackage

// File: rtl/perf_rr_arbiter.sv
// Round-robin grant: the requester just after the last grant is most preferred,
// the last-granted one is considered last.
module perf_rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last,
    output logic [N_REQ-1:0] grant
);

    logic found_s;
    logic hit_s;

    // Walk the ring starting one past the last grant; the first asserted request wins.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                hit_s    = !found_s && req[i] && (i == ((int'(last) + k) % N_REQ));
                grant[i] = grant[i] | hit_s;
                found_s  = found_s | hit_s;
            end
        end
    end

endmodule

// File: rtl/perf_counter_sequencer.sv
// Arbitrates requesters onto the counter slave: single writes for GO/STOP/CLEAR_ALL
// and a coherent HI/LO/HI/EV read sequence (one re-read on carry) for SNAPSHOT.
module perf_counter_sequencer
    import perf_ctl_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   req_cmd,
    input  logic [N_REQ-1:0]     req_sec,
    output logic [N_REQ-1:0]     ack,
    output logic                 busy,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_id,
    output logic [63:0]          rsp_time,
    output logic [31:0]          rsp_events,
    output logic                 rsp_retried,
    output logic [2:0]           cnt_address,
    output logic                 cnt_write,
    output logic                 cnt_begintransfer,
    output logic [31:0]          cnt_writedata,
    input  logic [31:0]          cnt_readdata
);

    state_e             state_r, state_s;
    logic [1:0]         ptr_r, last_s;
    logic [N_REQ-1:0]   grant_s;
    logic [1:0]         gid_s;
    cmd_e               cmd_sel_s, cmd_r, cmd_n_s;
    logic               sec_sel_s, sec_r, sec_n_s;
    logic [1:0]         id_r;
    logic [31:0]        hi0_r, lo_r, hi1_r;
    logic               retry_r, reread_s;
    logic               busy_r, rsp_valid_r;
    logic [2:0]         addr_s, base_s;
    logic               wr_s, bt_s;
    logic [31:0]        wd_s;

    // ptr_r names the most-preferred requester; the arbiter wants the one before it.
    assign last_s = (ptr_r == 2'd0) ? 2'(N_REQ - 1) : (ptr_r - 2'd1);

    perf_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req),
        .last  (last_s),
        .grant (grant_s)
    );

    assign ack      = ((state_r == IDLE) && reset_n) ? grant_s : '0;
    assign reread_s = !retry_r && (hi1_r != hi0_r);
    assign busy     = busy_r;
    assign rsp_valid = rsp_valid_r;

    // Pick index, command and section of the granted requester.
    always_comb begin
        gid_s     = 2'd0;
        cmd_sel_s = CMD_GO;
        sec_sel_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                gid_s     = 2'(i);
                cmd_sel_s = cmd_e'(req_cmd[2*i +: 2]);
                sec_sel_s = req_sec[i];
            end else begin
                gid_s     = gid_s;
            end
        end
        cmd_n_s = (state_r == IDLE) ? cmd_sel_s : cmd_r;
        sec_n_s = (state_r == IDLE) ? sec_sel_s : sec_r;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = (|req) ? ((cmd_sel_s == CMD_SNAPSHOT) ? RD_HI0 : WR) : IDLE;
            WR:      state_s = IDLE;
            RD_HI0:  state_s = RD_LO;
            RD_LO:   state_s = RD_HI1;
            RD_HI1:  state_s = RD_EV;
            RD_EV:   state_s = CHK;
            CHK:     state_s = reread_s ? RD_LO : RSP;
            RSP:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Slave bus values for the coming cycle, registered below.
    always_comb begin
        addr_s = 3'd0;
        wr_s   = 1'b0;
        bt_s   = 1'b0;
        wd_s   = 32'd0;
        base_s = sec_base(sec_n_s);
        case (state_s)
            WR: begin
                wr_s = 1'b1;
                bt_s = 1'b1;
                if (cmd_n_s == CMD_CLEAR_ALL) begin
                    addr_s = 3'd0;
                    wd_s   = 32'd1;
                end else if (cmd_n_s == CMD_GO) begin
                    addr_s = base_s + OFF_GO;
                end else begin
                    addr_s = base_s + OFF_STOP;
                end
            end
            RD_HI0, RD_HI1: begin
                bt_s   = 1'b1;
                addr_s = base_s + OFF_HI;
            end
            RD_LO: begin
                bt_s   = 1'b1;
                addr_s = base_s + OFF_LO;
            end
            RD_EV: begin
                bt_s   = 1'b1;
                addr_s = base_s + OFF_EV;
            end
            default: addr_s = 3'd0;
        endcase
    end

    // Control state, round-robin pointer and registered bus/busy outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r           <= IDLE;
            ptr_r             <= 2'd0;
            busy_r            <= 1'b0;
            cnt_address       <= 3'd0;
            cnt_write         <= 1'b0;
            cnt_begintransfer <= 1'b0;
            cnt_writedata     <= 32'd0;
            cmd_r             <= CMD_GO;
            sec_r             <= 1'b0;
            id_r              <= 2'd0;
        end else begin
            state_r           <= state_s;
            busy_r            <= (state_s != IDLE);
            cnt_address       <= addr_s;
            cnt_write         <= wr_s;
            cnt_begintransfer <= bt_s;
            cnt_writedata     <= wd_s;
            if ((state_r == IDLE) && (|req)) begin
                cmd_r <= cmd_sel_s;
                sec_r <= sec_sel_s;
                id_r  <= gid_s;
                ptr_r <= (gid_s == 2'(N_REQ - 1)) ? 2'd0 : (gid_s + 2'd1);
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // Read data lands one cycle after its address; the retry pass keeps HI0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi0_r       <= 32'd0;
            lo_r        <= 32'd0;
            hi1_r       <= 32'd0;
            retry_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_time    <= 64'd0;
            rsp_events  <= 32'd0;
            rsp_id      <= 2'd0;
            rsp_retried <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE:   retry_r <= 1'b0;
                RD_LO:  hi0_r <= retry_r ? hi0_r : cnt_readdata;
                RD_HI1: lo_r  <= cnt_readdata;
                RD_EV:  hi1_r <= cnt_readdata;
                CHK: begin
                    if (reread_s) begin
                        hi0_r   <= hi1_r;
                        retry_r <= 1'b1;
                    end else begin
                        rsp_valid_r <= 1'b1;
                        rsp_time    <= {hi0_r, lo_r};
                        rsp_events  <= cnt_readdata;
                        rsp_id      <= id_r;
                        rsp_retried <= retry_r;
                    end
                end
                default: retry_r <= retry_r;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_counter_sequencer.sv
// Directed bench for perf_counter_sequencer with a small counter-slave model.
module tb_perf_counter_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req;
    logic [3:0]  req_cmd;
    logic [1:0]  req_sec;
    logic [1:0]  ack;
    logic        busy;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [63:0] rsp_time;
    logic [31:0] rsp_events;
    logic        rsp_retried;
    logic [2:0]  cnt_address;
    logic        cnt_write;
    logic        cnt_begintransfer;
    logic [31:0] cnt_writedata;
    logic [31:0] cnt_readdata;

    // counter slave model state
    logic [63:0] tm [2];
    logic [31:0] ev [2];
    logic        run [2];
    logic        mrst;
    logic        load_en;
    logic        load_sec;
    logic [63:0] load_time;
    logic [31:0] load_ev;

    int n_assert = 0;
    int n_fail   = 0;

    perf_counter_sequencer #(.N_REQ(2)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (req),
        .req_cmd           (req_cmd),
        .req_sec           (req_sec),
        .ack               (ack),
        .busy              (busy),
        .rsp_valid         (rsp_valid),
        .rsp_id            (rsp_id),
        .rsp_time          (rsp_time),
        .rsp_events        (rsp_events),
        .rsp_retried       (rsp_retried),
        .cnt_address       (cnt_address),
        .cnt_write         (cnt_write),
        .cnt_begintransfer (cnt_begintransfer),
        .cnt_writedata     (cnt_writedata),
        .cnt_readdata      (cnt_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter slave: registered read data, free-running time when started.
    always @(posedge clk) begin
        case (cnt_address[1:0])
            2'd0:    cnt_readdata <= tm[cnt_address[2]][31:0];
            2'd1:    cnt_readdata <= tm[cnt_address[2]][63:32];
            2'd2:    cnt_readdata <= ev[cnt_address[2]];
            default: cnt_readdata <= 32'd0;
        endcase
        if (mrst || (cnt_write && cnt_address == 3'd0 && cnt_writedata == 32'd1)) begin
            for (int s = 0; s < 2; s++) begin
                tm[s]  <= 64'd0;
                ev[s]  <= 32'd0;
                run[s] <= 1'b0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (run[s]) tm[s] <= tm[s] + 64'd1;
            end
            if (load_en) begin
                tm[load_sec] <= load_time;
                ev[load_sec] <= load_ev;
            end
            if (cnt_write && cnt_address[1:0] == 2'd1) run[cnt_address[2]] <= 1'b1;
            if (cnt_write && cnt_address[1:0] == 2'd0) run[cnt_address[2]] <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = 2'b00;
        req_cmd   = 4'b0000;
        req_sec   = 2'b00;
        mrst      = 1'b1;
        load_en   = 1'b0;
        load_sec  = 1'b0;
        load_time = 64'd0;
        load_ev   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_bus", 64'({cnt_address, cnt_write, cnt_begintransfer, cnt_writedata}), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_id, rsp_retried, rsp_events}), 64'd0);
        chk("rst_time", rsp_time, 64'd0);

        // GO, section 1, from requester 0
        reset_n = 1'b1;
        mrst    = 1'b0;
        req     = 2'b01;
        req_cmd = 4'b0000;
        req_sec = 2'b01;
        #1;
        chk("go_ack", 64'(ack), 64'd1);
        chk("go_busy_c0", 64'(busy), 64'd0);
        tick;
        req = 2'b00;
        chk("go_addr", 64'(cnt_address), 64'd5);
        chk("go_wr_bt", 64'({cnt_write, cnt_begintransfer}), 64'd3);
        chk("go_data", 64'(cnt_writedata), 64'd0);
        chk("go_busy_c1", 64'(busy), 64'd1);
        tick;
        chk("go_busy_c2", 64'(busy), 64'd0);
        chk("go_idle_bus", 64'({cnt_address, cnt_write, cnt_begintransfer}), 64'd0);
        chk("go_model_run", 64'(run[1]), 64'd1);

        // CLEAR_ALL, section 1, from requester 1
        req     = 2'b10;
        req_cmd = 4'b1000;
        req_sec = 2'b10;
        #1;
        chk("clr_ack", 64'(ack), 64'd2);
        tick;
        req = 2'b00;
        chk("clr_addr", 64'(cnt_address), 64'd0);
        chk("clr_data", 64'(cnt_writedata), 64'd1);
        chk("clr_wr", 64'(cnt_write), 64'd1);
        tick;
        chk("clr_model_time", tm[0] | tm[1], 64'd0);
        chk("clr_model_ev", 64'(ev[0] | ev[1]), 64'd0);
        chk("clr_model_run", 64'({run[0], run[1]}), 64'd0);

        // preload both sections (stopped) for the snapshot pair
        load_en   = 1'b1;
        load_sec  = 1'b0;
        load_time = 64'h0000_0012_3456_7890;
        load_ev   = 32'h0000_0077;
        tick;
        load_sec  = 1'b1;
        load_time = 64'h0000_00AB_CDEF_0001;
        load_ev   = 32'h0000_1234;
        tick;
        load_en   = 1'b0;

        // two SNAPSHOT requests held together
        req     = 2'b11;
        req_cmd = 4'b1111;
        req_sec = 2'b10;
        #1;
        chk("snap_ack0", 64'(ack), 64'd1);
        tick;
        req = 2'b10;
        chk("snap_c1_addr", 64'(cnt_address), 64'd1);
        chk("snap_c1_wr", 64'(cnt_write), 64'd0);
        tick;
        chk("snap_c2_addr", 64'(cnt_address), 64'd0);
        tick;
        chk("snap_c3_addr", 64'(cnt_address), 64'd1);
        tick;
        chk("snap_c4_addr", 64'(cnt_address), 64'd2);
        tick;
        chk("snap_c5_valid", 64'(rsp_valid), 64'd0);
        tick;
        chk("snap0_valid", 64'(rsp_valid), 64'd1);
        chk("snap0_id", 64'(rsp_id), 64'd0);
        chk("snap0_time", rsp_time, 64'h0000_0012_3456_7890);
        chk("snap0_ev", 64'(rsp_events), 64'h77);
        chk("snap0_retried", 64'(rsp_retried), 64'd0);
        tick;
        chk("snap_ack1", 64'(ack), 64'd2);
        chk("snap0_pulse_end", 64'(rsp_valid), 64'd0);
        chk("snap0_time_hold", rsp_time, 64'h0000_0012_3456_7890);
        tick;
        req = 2'b00;
        chk("snap1_c1_addr", 64'(cnt_address), 64'd5);
        repeat (4) tick;
        chk("snap1_c5_valid", 64'(rsp_valid), 64'd0);
        tick;
        chk("snap1_valid", 64'(rsp_valid), 64'd1);
        chk("snap1_id", 64'(rsp_id), 64'd1);
        chk("snap1_time", rsp_time, 64'h0000_00AB_CDEF_0001);
        chk("snap1_ev", 64'(rsp_events), 64'h1234);
        tick;
        chk("snap1_done", 64'({rsp_valid, busy}), 64'd0);

        // start section 0, then snapshot across a carry of the low word
        req     = 2'b01;
        req_cmd = 4'b0000;
        req_sec = 2'b00;
        #1;
        chk("go0_ack", 64'(ack), 64'd1);
        tick;
        req = 2'b00;
        chk("go0_addr", 64'(cnt_address), 64'd1);
        tick;
        req       = 2'b01;
        req_cmd   = 4'b0011;
        #1;
        chk("retry_ack", 64'(ack), 64'd1);
        load_en   = 1'b1;
        load_sec  = 1'b0;
        load_time = 64'h0000_0000_FFFF_FFFE;
        load_ev   = 32'h0000_0055;
        tick;
        load_en = 1'b0;
        req     = 2'b00;
        repeat (8) tick;
        chk("retry_c9_valid", 64'(rsp_valid), 64'd0);
        tick;
        chk("retry_valid", 64'(rsp_valid), 64'd1);
        chk("retry_flag", 64'(rsp_retried), 64'd1);
        chk("retry_time", rsp_time, 64'h0000_0001_0000_0003);
        chk("retry_ev", 64'(rsp_events), 64'h55);
        tick;
        chk("retry_done", 64'(busy), 64'd0);

        // reset in RD_LO aborts the snapshot; RR pointer returns to requester 0
        req     = 2'b01;
        req_cmd = 4'b0011;
        req_sec = 2'b01;
        #1;
        chk("abort_ack", 64'(ack), 64'd1);
        tick;
        req = 2'b00;
        tick;
        chk("abort_rdlo_addr", 64'(cnt_address), 64'd4);
        req     = 2'b11;
        reset_n = 1'b0;
        #1;
        chk("abort_ack_gated", 64'(ack), 64'd0);
        chk("abort_bus", 64'({busy, cnt_address, cnt_write, cnt_begintransfer, cnt_writedata}), 64'd0);
        chk("abort_rsp", 64'({rsp_valid, rsp_id, rsp_retried, rsp_events}), 64'd0);
        chk("abort_time", rsp_time, 64'd0);
        repeat (2) tick;
        reset_n = 1'b1;
        req_cmd = 4'b0000;
        req_sec = 2'b00;
        #1;
        chk("post_rst_ack", 64'(ack), 64'd1);
        tick;
        req = 2'b10;
        chk("post_rst_addr", 64'(cnt_address), 64'd1);
        chk("post_rst_valid", 64'(rsp_valid), 64'd0);
        tick;
        chk("post_rst_ack1", 64'(ack), 64'd2);
        tick;
        req = 2'b00;
        chk("post_rst_wr1", 64'({cnt_address, cnt_write}), 64'({3'd1, 1'b1}));
        tick;
        chk("post_rst_idle", 64'({busy, rsp_valid}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
